// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and branch-controller state encoding.
package mips_pkg;

    localparam logic [5:0] OP_REGIMM = 6'b000001;  // bgez / bltz
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STALL   = 2'd1,
        ST_RESOLVE = 2'd2
    } br_state_e;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_BLEZ) ||
               (op == OP_BGTZ) || (op == OP_REGIMM);
    endfunction

    function automatic logic uses_rt(input logic [5:0] op);
        return (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/branch_hazard_detect.sv
// Combinational source-use decode and producer match for a branch sitting in ID.
module branch_hazard_detect
    import mips_pkg::*;
(
    input  logic [15:0] instr_hi,
    input  logic        id_valid,
    input  logic        ex_reg_write,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rd,
    input  logic        mem_reg_write,
    input  logic        mem_mem_read,
    input  logic [4:0]  mem_rd,
    output logic        is_branch,
    output logic        ex_load,
    output logic        ex_alu,
    output logic        mem_load,
    output logic        mem_fwd_rs,
    output logic        mem_fwd_rt
);

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       use_rs;
    logic       use_rt;
    logic       ex_hit;
    logic       mem_rs_hit;
    logic       mem_rt_hit;

    assign op = instr_hi[15:10];
    assign rs = instr_hi[9:5];
    assign rt = instr_hi[4:0];

    // Register 0 is hardwired, so a zero source never creates a dependency.
    assign is_branch = id_valid && is_branch_op(op);
    assign use_rs    = is_branch && (rs != 5'd0);
    assign use_rt    = is_branch && uses_rt(op) && (rt != 5'd0);

    assign ex_hit     = ex_reg_write && ((use_rs && (ex_rd == rs)) || (use_rt && (ex_rd == rt)));
    assign mem_rs_hit = mem_reg_write && use_rs && (mem_rd == rs);
    assign mem_rt_hit = mem_reg_write && use_rt && (mem_rd == rt);

    assign ex_load    = ex_hit && ex_mem_read;
    assign ex_alu     = ex_hit && !ex_mem_read;
    assign mem_load   = (mem_rs_hit || mem_rt_hit) && mem_mem_read;
    assign mem_fwd_rs = mem_rs_hit && !mem_mem_read;
    assign mem_fwd_rt = mem_rt_hit && !mem_mem_read;

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch controller: hazard stalls, forwarding selects, taken/flush and stall counter.
module branch_ctrl
    import mips_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IF_ID_instr,
    input  logic        ID_valid,
    input  logic        ID_EX_RegWrite,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_rd,
    input  logic        EX_MEM_RegWrite,
    input  logic        EX_MEM_MemRead,
    input  logic [4:0]  EX_MEM_rd,
    input  logic        Compare_o,
    output logic        stall_o,
    output logic        bubble_o,
    output logic        fwd_rs_o,
    output logic        fwd_rt_o,
    output logic        branch_taken_o,
    output logic        flush_o,
    output logic [15:0] stall_cnt_o
);

    logic is_branch, ex_load, ex_alu, mem_load, mem_fwd_rs, mem_fwd_rt;
    logic unused_instr_lo;

    assign unused_instr_lo = ^IF_ID_instr[15:0];

    branch_hazard_detect u_hazard (
        .instr_hi      (IF_ID_instr[31:16]),
        .id_valid      (ID_valid),
        .ex_reg_write  (ID_EX_RegWrite),
        .ex_mem_read   (ID_EX_MemRead),
        .ex_rd         (ID_EX_rd),
        .mem_reg_write (EX_MEM_RegWrite),
        .mem_mem_read  (EX_MEM_MemRead),
        .mem_rd        (EX_MEM_rd),
        .is_branch     (is_branch),
        .ex_load       (ex_load),
        .ex_alu        (ex_alu),
        .mem_load      (mem_load),
        .mem_fwd_rs    (mem_fwd_rs),
        .mem_fwd_rt    (mem_fwd_rt)
    );

    br_state_e   state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        flush_q, flush_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        stall, bubble, fwd_rs, fwd_rt, taken;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall   = 1'b0;
        bubble  = 1'b0;
        fwd_rs  = 1'b0;
        fwd_rt  = 1'b0;
        taken   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // The instruction behind a taken branch is being flushed, so ignore it.
                if (is_branch && !flush_q) begin
                    if (ex_load) begin
                        state_d = ST_STALL;
                        cnt_d   = 2'd2;
                    end else if (ex_alu || mem_load) begin
                        state_d = ST_STALL;
                        cnt_d   = 2'd1;
                    end else begin
                        fwd_rs = mem_fwd_rs;
                        fwd_rt = mem_fwd_rt;
                        taken  = Compare_o;
                    end
                end
            end
            ST_STALL: begin
                // Losing the branch mid-stall aborts quietly back to IDLE.
                if (!is_branch) begin
                    state_d = ST_IDLE;
                    cnt_d   = 2'd0;
                end else begin
                    stall  = 1'b1;
                    bubble = 1'b1;
                    cnt_d  = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = ST_RESOLVE;
                end
            end
            ST_RESOLVE: begin
                state_d = ST_IDLE;
                if (is_branch) begin
                    fwd_rs = mem_fwd_rs;
                    fwd_rt = mem_fwd_rt;
                    taken  = Compare_o;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        flush_d     = taken;
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            flush_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flush_q     <= flush_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational outputs are masked so reset silences them without waiting for a clock.
    assign stall_o        = stall  && !rst;
    assign bubble_o       = bubble && !rst;
    assign fwd_rs_o       = fwd_rs && !rst;
    assign fwd_rt_o       = fwd_rt && !rst;
    assign branch_taken_o = taken  && !rst;
    assign flush_o        = flush_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] IF_ID_instr;
    logic        ID_valid;
    logic        ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]  ID_EX_rd;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]  EX_MEM_rd;
    logic        Compare_o;
    logic        stall_o, bubble_o, fwd_rs_o, fwd_rt_o, branch_taken_o, flush_o;
    logic [15:0] stall_cnt_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .IF_ID_instr    (IF_ID_instr),
        .ID_valid       (ID_valid),
        .ID_EX_RegWrite (ID_EX_RegWrite),
        .ID_EX_MemRead  (ID_EX_MemRead),
        .ID_EX_rd       (ID_EX_rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .EX_MEM_MemRead (EX_MEM_MemRead),
        .EX_MEM_rd      (EX_MEM_rd),
        .Compare_o      (Compare_o),
        .stall_o        (stall_o),
        .bubble_o       (bubble_o),
        .fwd_rs_o       (fwd_rs_o),
        .fwd_rt_o       (fwd_rt_o),
        .branch_taken_o (branch_taken_o),
        .flush_o        (flush_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
        return {op, rs, rt, 16'h1234};
    endfunction

    // Behavioural model: remaining stall cycles, pending resolve, pending flush, stall tally.
    int m_left = 0;
    bit m_res = 0;
    bit m_flush = 0;
    int m_cnt = 0;

    always @(negedge clk) begin
        logic [5:0] op;
        logic [4:0] rs, rt;
        bit isb, rt_used, exm, mrs, mrt, do_res;
        bit es, eb, efr, eft, et, ef;
        int ec, lat;
        op = IF_ID_instr[31:26];
        rs = IF_ID_instr[25:21];
        rt = IF_ID_instr[20:16];
        isb = ID_valid && (op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7 || op == 6'd1);
        rt_used = (op == 6'd4 || op == 6'd5);
        exm = isb && ID_EX_RegWrite &&
              ((rs != 0 && ID_EX_rd == rs) || (rt_used && rt != 0 && ID_EX_rd == rt));
        mrs = isb && EX_MEM_RegWrite && rs != 0 && EX_MEM_rd == rs;
        mrt = isb && EX_MEM_RegWrite && rt_used && rt != 0 && EX_MEM_rd == rt;
        {es, eb, efr, eft, et, do_res} = '0;
        if (rst) begin
            m_left = 0; m_res = 0; m_flush = 0; m_cnt = 0;
            ef = 0; ec = 0;
        end else begin
            ef = m_flush;
            ec = m_cnt;
            if (m_left > 0) begin
                if (!isb) m_left = 0;
                else begin
                    es = 1; eb = 1;
                    m_left--;
                    if (m_left == 0) m_res = 1;
                end
            end else if (m_res) begin
                m_res = 0;
                do_res = isb;
            end else if (isb && !m_flush) begin
                if (exm) lat = ID_EX_MemRead ? 2 : 1;
                else if ((mrs || mrt) && EX_MEM_MemRead) lat = 1;
                else lat = 0;
                if (lat > 0) m_left = lat;
                else do_res = 1;
            end
            if (do_res) begin
                efr = mrs && !EX_MEM_MemRead;
                eft = mrt && !EX_MEM_MemRead;
                et  = Compare_o;
            end
            if (es && m_cnt < 65535) m_cnt++;
            m_flush = et;
        end
        check("stall",     {15'd0, stall_o},        {15'd0, es});
        check("bubble",    {15'd0, bubble_o},       {15'd0, eb});
        check("fwd_rs",    {15'd0, fwd_rs_o},       {15'd0, efr});
        check("fwd_rt",    {15'd0, fwd_rt_o},       {15'd0, eft});
        check("taken",     {15'd0, branch_taken_o}, {15'd0, et});
        check("flush",     {15'd0, flush_o},        {15'd0, ef});
        check("stall_cnt", stall_cnt_o,             ec[15:0]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_prod();
        ID_EX_RegWrite = 0; ID_EX_MemRead = 0; ID_EX_rd = '0;
        EX_MEM_RegWrite = 0; EX_MEM_MemRead = 0; EX_MEM_rd = '0;
    endtask

    task automatic chk_all_zero(input string nm);
        check({nm, "_zero"}, {stall_o, bubble_o, fwd_rs_o, fwd_rt_o, branch_taken_o, flush_o, 10'd0}, '0);
        check({nm, "_cnt"}, stall_cnt_o, 16'd0);
    endtask

    initial begin
        rst = 1; IF_ID_instr = '0; ID_valid = 0; Compare_o = 0;
        clr_prod();
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst = 0;

        // beq r3,r4 with no producers: taken now, flush next cycle
        IF_ID_instr = mk(6'b000100, 5'd3, 5'd4); ID_valid = 1; Compare_o = 1;
        #1;
        check("beq_taken", {15'd0, branch_taken_o}, 16'd1);
        check("beq_nostall", {15'd0, stall_o}, 16'd0);
        step();
        check("beq_flush", {15'd0, flush_o}, 16'd1);
        check("beq_cnt", stall_cnt_o, 16'd0);

        // branch in the flush shadow is ignored even with a load hazard
        IF_ID_instr = mk(6'b000101, 5'd5, 5'd0); Compare_o = 0;
        ID_EX_RegWrite = 1; ID_EX_MemRead = 1; ID_EX_rd = 5'd5;
        #1;
        check("shadow_stall", {15'd0, stall_o}, 16'd0);
        check("shadow_taken", {15'd0, branch_taken_o}, 16'd0);
        step();
        check("detect_flush", {15'd0, flush_o}, 16'd0);
        check("detect_stall", {15'd0, stall_o}, 16'd0);
        step();
        check("load_stall1", {14'd0, stall_o, bubble_o}, 16'd3);
        step();
        check("load_stall2", {15'd0, stall_o}, 16'd1);
        step();
        check("resolve_stall", {15'd0, stall_o}, 16'd0);
        check("resolve_cnt", stall_cnt_o, 16'd2);

        // blez r0,r7: rt unused and rs is r0, so no hazard
        step();
        clr_prod();
        IF_ID_instr = mk(6'b000110, 5'd0, 5'd7); Compare_o = 1;
        ID_EX_RegWrite = 1; ID_EX_MemRead = 1; ID_EX_rd = 5'd7;
        #1;
        check("blez_stall", {15'd0, stall_o}, 16'd0);
        check("blez_taken", {15'd0, branch_taken_o}, 16'd1);
        step();
        check("blez_flush", {15'd0, flush_o}, 16'd1);
        ID_valid = 0; clr_prod(); Compare_o = 0;

        // beq r2,r9 with EX_MEM ALU producer of r2: forward rs only
        step();
        ID_valid = 1; IF_ID_instr = mk(6'b000100, 5'd2, 5'd9);
        EX_MEM_RegWrite = 1; EX_MEM_MemRead = 0; EX_MEM_rd = 5'd2;
        #1;
        check("fwd_rs_only", {14'd0, fwd_rs_o, fwd_rt_o}, 16'd2);
        check("fwd_nostall", {15'd0, stall_o}, 16'd0);

        // reset in the middle of a two-cycle stall
        step();
        clr_prod();
        IF_ID_instr = mk(6'b000101, 5'd5, 5'd0);
        ID_EX_RegWrite = 1; ID_EX_MemRead = 1; ID_EX_rd = 5'd5;
        step();
        check("pre_rst_stall", {15'd0, stall_o}, 16'd1);
        #2 rst = 1;
        #1;
        chk_all_zero("async_rst");
        @(negedge clk);
        @(posedge clk);
        #1 rst = 0;
        IF_ID_instr = mk(6'b000000, 5'd5, 5'd5);
        #1;
        check("post_rst_stall", {15'd0, stall_o}, 16'd0);

        // randomized traffic; the per-cycle checker does the comparing
        for (int i = 0; i < 4000; i++) begin
            step();
            if (rst) rst = 0;
            else if ($urandom_range(199) == 0) rst = 1;
            if ($urandom_range(3) == 0) begin
                logic [5:0] ops [8];
                ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd0, 6'd35, 6'd43};
                IF_ID_instr = mk(ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)));
            end
            if ($urandom_range(9) == 0) ID_valid = ~ID_valid;
            ID_EX_RegWrite  = 1'($urandom);
            ID_EX_MemRead   = 1'($urandom);
            ID_EX_rd        = 5'($urandom_range(3));
            EX_MEM_RegWrite = 1'($urandom);
            EX_MEM_MemRead  = 1'($urandom);
            EX_MEM_rd       = 5'($urandom_range(3));
            Compare_o       = 1'($urandom);
        end
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-003 SHALL have port IF_ID_instr, input, 32, instruction in ID; [31:26] opcode, [25:21] rs, [20:16] rt.
REQ-004 SHALL have port ID_valid, input, 1, IF_ID_instr holds a real instruction.
REQ-005 SHALL have ports ID_EX_RegWrite, ID_EX_MemRead, input, 1 each, and ID_EX_rd, input, 5; describe the EX-stage producer.
REQ-006 SHALL have ports EX_MEM_RegWrite, EX_MEM_MemRead, input, 1 each, and EX_MEM_rd, input, 5; describe the MEM-stage producer.
REQ-007 SHALL have port Compare_o, input, 1, branch condition from the ID compare unit.
REQ-008 SHALL have ports stall_o, bubble_o, fwd_rs_o, fwd_rt_o, branch_taken_o, flush_o, output, 1 each.
REQ-009 SHALL have port stall_cnt_o, output, 16, saturating count of branch stall cycles.

Function
REQ-010 Branch SHALL mean ID_valid=1 and opcode 000100 (beq), 000101 (bne), 000110 (blez), 000111 (bgtz) or 000001 (bgez/bltz).
REQ-011 rs SHALL be a source for every branch; rt SHALL be a source only for beq/bne; register 0 SHALL never cause a hazard.
REQ-012 Match SHALL mean producer RegWrite=1 and rd equal to a nonzero source.
REQ-013 FSM states SHALL be IDLE, STALL, RESOLVE; encoding 2 bits.
REQ-014 IDLE, branch: ID_EX match with MemRead=1 -> STALL, counter=2; ID_EX match with MemRead=0 -> STALL, counter=1; else EX_MEM match with MemRead=1 -> STALL, counter=1; else resolve in the same cycle and stay IDLE.
REQ-015 ID_EX hazards SHALL take priority over EX_MEM hazards.
REQ-016 In STALL, stall_o=1 and bubble_o=1 every cycle; counter decrements; at 1 -> RESOLVE next cycle.
REQ-017 In RESOLVE, state SHALL return to IDLE after one cycle; stall_o=0.
REQ-018 Resolve cycle: fwd_rs_o/fwd_rt_o=1 if EX_MEM matches that source with MemRead=0; branch_taken_o=Compare_o, combinational; else both 0.
REQ-019 flush_o SHALL be registered: exactly one-cycle pulse in the cycle after branch_taken_o=1.
REQ-020 While flush_o=1, the ID instruction SHALL be treated as non-branch (no stall, no taken).
REQ-021 ID_valid falling during STALL SHALL abort to IDLE next cycle; no taken, no flush.
REQ-022 stall_cnt_o SHALL increment on each cycle stall_o=1, saturating at 16'hFFFF.
REQ-023 Non-branch instructions SHALL leave all 1-bit outputs 0.
REQ-024 Latency: 0 stalls (no hazard or EX_MEM ALU forward), 1 (ID_EX ALU or EX_MEM load), 2 (ID_EX load).

Reset
REQ-025 rst=1 SHALL immediately force state IDLE, counter 0, flush_o 0, stall_cnt_o 0, all outputs 0, including mid-stall.
REQ-026 First branch after rst release SHALL be evaluated normally on the first clock edge.

Structure
REQ-027 Opcode constants and FSM state encodings SHALL reside in shared package mips_pkg.
REQ-028 Source-use decode and match logic SHALL be a combinational sub-module branch_hazard_detect; the FSM, counters and flush register stay in branch_ctrl.

Verification
REQ-029 beq rs=3,rt=4, no producer matches, Compare_o=1 -> branch_taken_o=1 same cycle, flush_o=1 next cycle, stall_cnt_o=0.
REQ-030 bne rs=5; ID_EX_rd=5, RegWrite=1, MemRead=1 -> stall_o=1 two cycles, then RESOLVE, stall_cnt_o=2.
REQ-031 blez rs=0, rt=7; ID_EX_rd=7 RegWrite=1 -> no stall (rt unused, rs=0), resolves immediately.
REQ-032 beq rs=2; EX_MEM_rd=2 RegWrite=1 MemRead=0 -> fwd_rs_o=1, fwd_rt_o=0, no stall.
REQ-033 rst asserted during 2-cycle stall -> all outputs 0 asynchronously; after release, non-branch -> stall_o=0.
REQ-034 Taken branch followed by branch opcode in flush cycle -> no stall, branch_taken_o=0 in that cycle.
